pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 5, is the score at which a player wins (range 1..15).
REQ-002 Parameter BALL_WAIT_TICKS, default 120, is the number of 60 Hz frame ticks held in NEWBALL and OVER (2 s).
REQ-003 clk  in  1  system clock; the block has one clock only.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 btn  in  4  debounced buttons: [1:0] player2 down/up, [3:2] player1 down/up; any bit set counts as a "start press".
REQ-006 x, y  in  10 each  current pixel coordinates from the VGA sync generator.
REQ-007 hit  in  2  out-of-bounds side from the graphics block: 2'b10 = ball exited right (player1 scores), 2'b01 = ball exited left (player2 scores).
REQ-008 miss  in  1  level, high while the ball is out of bounds; it may stay high for many cycles.
REQ-009 gra_still  out  1  registered; high freezes and re-centres the ball in the graphics block.
REQ-010 p1_score, p2_score  out  4 each  registered binary scores.
REQ-011 game_over  out  1  registered; high only in OVER.
REQ-012 winner  out  2  registered: 2'b01 = player1, 2'b10 = player2, 2'b00 = none.

Function
REQ-013 Frame tick: a one-cycle internal pulse when y == 481 and x == 0.
REQ-014 FSM states: NEWGAME, PLAY, NEWBALL, OVER.
REQ-015 NEWGAME:
  - gra_still = 1.
  - Scores held at 0; winner = 0.
  - Goes to PLAY on the first clock edge with btn != 0.
REQ-016 PLAY:
  - gra_still = 0.
  - When miss = 1, the FSM leaves PLAY on the next edge, so exactly one score event is taken per miss episode regardless of how long miss stays high.
REQ-017 Score event (taken on the PLAY exit edge):
  - hit = 2'b10: p1_score += 1.
  - hit = 2'b01: p2_score += 1.
  - hit = 2'b00 or 2'b11: no score change.
  - Next state is OVER if the incremented score equals WIN_SCORE; otherwise NEWBALL.
REQ-018 The score registers, gra_still and next state all update on the same edge, one cycle after miss is sampled high.
REQ-019 NEWBALL:
  - gra_still = 1.
  - On entry the wait timer loads BALL_WAIT_TICKS.
  - Each frame tick decrements the timer.
  - The FSM returns to PLAY on the edge after the timer reaches 0, i.e. exactly BALL_WAIT_TICKS ticks later.
  - miss and btn are ignored in NEWBALL.
REQ-020 OVER:
  - gra_still = 1, game_over = 1, winner set on entry.
  - The timer loads BALL_WAIT_TICKS on entry.
  - When the timer expires the FSM goes to NEWGAME, which clears scores, winner and game_over on the same edge.
REQ-021 Scores never exceed WIN_SCORE and never wrap; if both conditions could apply, player1 is credited first (cannot occur with a legal hit).
REQ-022 A frame tick on the entry edge is not counted; counting starts from the first tick after entry.
REQ-023 Timer width is the minimum needed for BALL_WAIT_TICKS (7 bits for 120); there is no underflow, and the timer holds at 0.

Reset
REQ-024 Reset values: state = NEWGAME, gra_still = 1, p1_score = 0, p2_score = 0, game_over = 0, winner = 0, timer = 0.
REQ-025 Reset asserted mid-operation (any state, any timer value) takes effect on the next edge with the values in REQ-024; pending score events are discarded.

Structure
REQ-026 The state encoding, the WIN_SCORE and BALL_WAIT_TICKS defaults, and the frame-tick coordinates (481, 0) live in the shared package pong_pkg.
REQ-027 The wait timer is a sub-module pong_timer:
  - Inputs: clk, reset, load, tick.
  - Output: done.
  - Instantiated once and shared by NEWBALL and OVER.

Verification
REQ-028 Reset, then btn = 4'b0001 for 1 cycle -> state PLAY next edge, gra_still = 0, scores 0/0.
REQ-029 In PLAY, hit = 2'b10 with miss high for 50 cycles -> p1_score = 1 (not 50), gra_still = 1 one cycle after miss rises, NEWBALL held for exactly 120 frame ticks, then PLAY.
REQ-030 p2_score = 4, hit = 2'b01 with miss high -> p2_score = 5, game_over = 1, winner = 2'b10; 120 ticks later -> NEWGAME with scores 0/0 and game_over = 0.
REQ-031 hit = 2'b11 with miss high in PLAY -> NEWBALL entered, both scores unchanged.
REQ-032 Reset asserted in NEWBALL with timer = 60 -> next edge NEWGAME, gra_still = 1, all outputs at reset values; btn held during NEWBALL has no effect.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared FSM encoding, parameter defaults and frame-tick coordinates
package pong_pkg;
  typedef enum logic [1:0] {NEWGAME, PLAY, NEWBALL, OVER} state_t;
  localparam int WIN_SCORE_DEF = 5;
  localparam int BALL_WAIT_DEF = 120;
  localparam int TICK_Y = 481;
  localparam int TICK_X = 0;
endpackage

// File: rtl/pong_timer.sv
// pong_timer: frame-tick down-counter (ports: clk, reset, load, tick in; done out), saturates at 0
module pong_timer #(
  parameter int TICKS = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic done
);
  localparam int W = $clog2(TICKS + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= W'(TICKS);
    else if (tick && cnt != '0) cnt <= cnt - W'(1);
  assign done = cnt == '0;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong scoring FSM (in: clk, reset, btn, x, y, hit, miss; out: gra_still, p1_score, p2_score, game_over, winner)
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE       = WIN_SCORE_DEF,
  parameter int BALL_WAIT_TICKS = BALL_WAIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       game_over,
  output logic [1:0] winner
);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  state_t state, state_nx;
  logic tick, done, load, p1_up, p2_up, win_now;
  logic [3:0] p1_nx, p2_nx;
  assign tick = y == 10'(TICK_Y) && x == 10'(TICK_X);
  pong_timer #(.TICKS(BALL_WAIT_TICKS)) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .tick (tick),
    .done (done)
  );
  always_comb begin
    p1_up   = hit == 2'b10 && p1_score < WIN;
    p2_up   = hit == 2'b01 && p2_score < WIN && !p1_up;
    p1_nx   = p1_score + {3'b0, p1_up};
    p2_nx   = p2_score + {3'b0, p2_up};
    win_now = (p1_up && p1_nx == WIN) || (p2_up && p2_nx == WIN);
    load    = state == PLAY && miss;
    state_nx = state;
    case (state)
      NEWGAME: state_nx = btn != '0 ? PLAY : NEWGAME;
      PLAY:    state_nx = !miss ? PLAY : win_now ? OVER : NEWBALL;
      NEWBALL: state_nx = done ? PLAY : NEWBALL;
      OVER:    state_nx = done ? NEWGAME : OVER;
      default: state_nx = NEWGAME;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state     <= NEWGAME;
      gra_still <= 1'b1;
      p1_score  <= '0;
      p2_score  <= '0;
      game_over <= 1'b0;
      winner    <= '0;
    end else begin
      state     <= state_nx;
      gra_still <= state_nx != PLAY;
      game_over <= state_nx == OVER;
      if (state_nx == NEWGAME) begin
        p1_score <= '0;
        p2_score <= '0;
        winner   <= '0;
      end else if (load) begin
        p1_score <= p1_nx;
        p2_score <= p2_nx;
        if (win_now) winner <= p1_up ? 2'b01 : 2'b10;
      end
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed bench with a phase-level reference model for pong_game_ctrl
module tb_pong_game_ctrl;
  localparam int WIN = 5;
  localparam int BW = 120;
  logic clk = 0, reset = 1, miss = 0, gra_still, game_over;
  logic [3:0] btn = 0, p1_score, p2_score;
  logic [9:0] x = 10'd5, y = 10'd100;
  logic [1:0] hit = 0, winner;
  int checks = 0, failures = 0, tick_cnt = 0, base = 0;
  bit chk_en = 0, ok;
  int m_ph = 0, m_p1 = 0, m_p2 = 0, m_left = 0, m_win = 0;

  pong_game_ctrl dut (
    .clk(clk), .reset(reset), .btn(btn), .x(x), .y(y), .hit(hit), .miss(miss),
    .gra_still(gra_still), .p1_score(p1_score), .p2_score(p2_score),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // frame tick every third cycle
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 3;
      x = ph == 0 ? 10'd0 : 10'd5;
      y = ph == 0 ? 10'd481 : 10'd100;
    end
  end

  // ticks seen while the ball is held still
  always @(posedge clk)
    if (!reset && gra_still === 1'b1 && x == 0 && y == 481) tick_cnt <= tick_cnt + 1;

  // reference model: phase 0 new game, 1 play, 2 ball wait, 3 over
  always @(posedge clk) begin
    automatic bit tk = x == 0 && y == 481;
    automatic int a = m_p1 + ((hit == 2'b10 && m_p1 < WIN) ? 1 : 0);
    automatic int b = m_p2 + ((hit == 2'b01 && m_p2 < WIN) ? 1 : 0);
    if (reset) begin
      m_ph <= 0; m_p1 <= 0; m_p2 <= 0; m_left <= 0; m_win <= 0;
    end else if (m_ph == 0) begin
      if (btn != 0) m_ph <= 1;
    end else if (m_ph == 1) begin
      if (miss) begin
        m_p1 <= a; m_p2 <= b; m_left <= BW;
        if (a == WIN && m_p1 != WIN) begin m_ph <= 3; m_win <= 1; end
        else if (b == WIN && m_p2 != WIN) begin m_ph <= 3; m_win <= 2; end
        else m_ph <= 2;
      end
    end else if (m_left == 0) begin
      m_ph <= m_ph == 2 ? 1 : 0;
      if (m_ph == 3) begin m_p1 <= 0; m_p2 <= 0; m_win <= 0; end
    end else if (tk) m_left <= m_left - 1;
  end

  always @(negedge clk)
    if (chk_en) begin
      chk("m_gra_still", int'(gra_still), int'(m_ph != 1));
      chk("m_p1_score", int'(p1_score), m_p1);
      chk("m_p2_score", int'(p2_score), m_p2);
      chk("m_game_over", int'(game_over), int'(m_ph == 3));
      chk("m_winner", int'(winner), m_win);
    end

  task automatic wait_play(output bit done);
    done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      done = !gra_still;
    end
  endtask

  task automatic wait_newgame(output bit done);
    done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      done = !game_over;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_gra_still"}, int'(gra_still), 1);
    chk({tag, "_p1"}, int'(p1_score), 0);
    chk({tag, "_p2"}, int'(p2_score), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
    chk({tag, "_winner"}, int'(winner), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset");
    chk_en = 1;
    reset = 0;
    @(negedge clk); btn = 4'b0001;
    @(negedge clk); btn = 0;
    chk("start_gra_still", int'(gra_still), 0);
    chk("start_p1", int'(p1_score), 0);
    // long miss episode credits player1 once
    base = tick_cnt; hit = 2'b10; miss = 1;
    @(negedge clk);
    chk("miss_gra_still", int'(gra_still), 1);
    chk("miss_p1", int'(p1_score), 1);
    repeat (49) @(negedge clk);
    chk("miss50_p1", int'(p1_score), 1);
    miss = 0; hit = 0;
    wait_play(ok);
    chk("newball_return", int'(ok), 1);
    chk("newball_ticks", tick_cnt - base, BW);
    // illegal hit value scores nobody
    @(negedge clk); hit = 2'b11; miss = 1;
    @(negedge clk); miss = 0; hit = 0;
    chk("hit11_gra_still", int'(gra_still), 1);
    chk("hit11_p1", int'(p1_score), 1);
    chk("hit11_p2", int'(p2_score), 0);
    wait_play(ok);
    chk("hit11_return", int'(ok), 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); hit = 2'b01; miss = 1;
      @(negedge clk); miss = 0; hit = 0;
      chk("p2_step", int'(p2_score), i);
      chk("p2_step_game_over", int'(game_over), 0);
      wait_play(ok);
      chk("p2_step_return", int'(ok), 1);
    end
    // winning point
    @(negedge clk); base = tick_cnt; hit = 2'b01; miss = 1;
    @(negedge clk); miss = 0; hit = 0;
    chk("win_p2", int'(p2_score), 5);
    chk("win_game_over", int'(game_over), 1);
    chk("win_winner", int'(winner), 2);
    wait_newgame(ok);
    chk("over_exit", int'(ok), 1);
    chk("over_ticks", tick_cnt - base, BW);
    check_idle("newgame");
    // reset in the middle of a ball wait, with buttons held
    @(negedge clk); btn = 4'b0100;
    @(negedge clk); btn = 0; hit = 2'b10; miss = 1;
    @(negedge clk); miss = 0; hit = 0; base = tick_cnt; btn = 4'b1111;
    for (int i = 0; i < 1000 && tick_cnt - base < 60; i++) @(negedge clk);
    chk("mid_ticks", tick_cnt - base, 60);
    chk("mid_gra_still", int'(gra_still), 1);
    chk("mid_p1", int'(p1_score), 1);
    reset = 1;
    @(negedge clk);
    check_idle("midreset");
    reset = 0; btn = 0;
    repeat (5) @(negedge clk);
    check_idle("post_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
